// File: rtl/axis_sched_pkg.sv
// ---------------------------------------------------------------------------
// axis_sched_pkg
//   Shared definitions for the stream-switch schedulers.
//   - sched_state_t : arbiter FSM encoding (IDLE = 0, GRANT = 1)
//   - weight_lsb()  : bit offset of a port's field inside a packed
//                     PORTS*WEIGHT_WIDTH weight vector
// ---------------------------------------------------------------------------
package axis_sched_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } sched_state_t;

    // Port 0 occupies the least significant field of the packed weight vector.
    function automatic int weight_lsb(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/axis_wrr_arbiter_if.sv
// ---------------------------------------------------------------------------
// axis_wrr_arbiter_if
//   Request/grant bundle between the requesters and the weighted arbiter.
//   Signals:
//     request       [PORTS]               packet pending per port
//     acknowledge   [PORTS]               tlast handshake of a port this cycle
//     cfg_weight    [PORTS*WEIGHT_WIDTH]  packets per round, 0 disables a port
//     grant         [PORTS]               one-hot grant
//     grant_valid                         a grant is active
//     grant_encoded [CL_PORTS]            index of the granted port
//     round_start                         credits reloaded with this grant
//   Modports:
//     master : the arbiter (drives grant side)
//     slave  : requesters / configuration (drive request side)
// ---------------------------------------------------------------------------
interface axis_wrr_arbiter_if #(
    parameter int PORTS        = 4,
    parameter int WEIGHT_WIDTH = 4,
    parameter int CL_PORTS     = $clog2(PORTS)
) ();

    logic [PORTS-1:0]              request;
    logic [PORTS-1:0]              acknowledge;
    logic [PORTS*WEIGHT_WIDTH-1:0] cfg_weight;
    logic [PORTS-1:0]              grant;
    logic                          grant_valid;
    logic [CL_PORTS-1:0]           grant_encoded;
    logic                          round_start;

    modport master (
        input  request,
        input  acknowledge,
        input  cfg_weight,
        output grant,
        output grant_valid,
        output grant_encoded,
        output round_start
    );

    modport slave (
        output request,
        output acknowledge,
        output cfg_weight,
        input  grant,
        input  grant_valid,
        input  grant_encoded,
        input  round_start
    );

endinterface

// File: rtl/axis_rr_pick.sv
// ---------------------------------------------------------------------------
// axis_rr_pick
//   Combinational rotating-priority picker. Scans eligible starting at ptr,
//   then ptr+1, ... modulo PORTS, and reports the first set bit.
//   Ports:
//     eligible    [PORTS]     candidate vector
//     ptr         [CL_PORTS]  index with highest priority
//     pick_onehot [PORTS]     one-hot winner (0 when none)
//     pick_index  [CL_PORTS]  encoded winner (0 when none)
//     found                   at least one candidate was eligible
// ---------------------------------------------------------------------------
module axis_rr_pick #(
    parameter int PORTS    = 4,
    parameter int CL_PORTS = $clog2(PORTS)
) (
    input  logic [PORTS-1:0]    eligible,
    input  logic [CL_PORTS-1:0] ptr,
    output logic [PORTS-1:0]    pick_onehot,
    output logic [CL_PORTS-1:0] pick_index,
    output logic                found
);

    int idx;

    // Walk from the farthest offset back to ptr so the closest eligible
    // port (smallest rotation offset) is the last one written and wins.
    always_comb begin
        pick_onehot = '0;
        pick_index  = '0;
        found       = 1'b0;
        idx         = 0;
        for (int k = PORTS - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % PORTS;
            if (eligible[idx]) begin
                pick_onehot      = '0;
                pick_onehot[idx] = 1'b1;
                pick_index       = CL_PORTS'(idx);
                found            = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axis_wrr_arbiter.sv
// ---------------------------------------------------------------------------
// axis_wrr_arbiter
//   Packet-granular weighted round-robin arbiter for one AXI-Stream output.
//   Each port may win cfg_weight[i] packets per round; a grant is held from
//   selection until the granted port acknowledges its tlast beat.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous, active-low reset
//     bus    axis_wrr_arbiter_if.master (request/acknowledge/cfg_weight in,
//            grant/grant_valid/grant_encoded/round_start out, all registered)
// ---------------------------------------------------------------------------
module axis_wrr_arbiter
    import axis_sched_pkg::*;
#(
    parameter int PORTS        = 4,
    parameter int WEIGHT_WIDTH = 4,
    parameter int CL_PORTS     = $clog2(PORTS)
) (
    input  logic               clk,
    input  logic               rst_n,
    axis_wrr_arbiter_if.master bus
);

    sched_state_t state_reg, state_next;

    logic [PORTS-1:0]        grant_reg, grant_next;
    logic                    grant_valid_reg, grant_valid_next;
    logic [CL_PORTS-1:0]     grant_enc_reg, grant_enc_next;
    logic                    round_start_reg, round_start_next;
    logic [CL_PORTS-1:0]     ptr_reg, ptr_next;

    logic [WEIGHT_WIDTH-1:0] weight_field [PORTS];
    logic [WEIGHT_WIDTH-1:0] credit_reg   [PORTS];
    logic [WEIGHT_WIDTH-1:0] credit_next  [PORTS];

    logic [PORTS-1:0]        weight_nz;
    logic [PORTS-1:0]        credit_nz;
    logic [PORTS-1:0]        live_req;
    logic [PORTS-1:0]        eligible;
    logic [PORTS-1:0]        pick_elig;

    logic [PORTS-1:0]        pick_onehot;
    logic [CL_PORTS-1:0]     pick_index;
    logic                    pick_found;

    logic                    need_reload;
    logic                    reload;
    logic                    consume;
    logic                    ack_granted;
    logic                    last_credit;

    // ------------------------------------------------------------------
    // Per-port weight decode, eligibility and credit counters
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < PORTS; gi++) begin : g_port
            assign weight_field[gi] = bus.cfg_weight[weight_lsb(gi, WEIGHT_WIDTH) +: WEIGHT_WIDTH];
            assign weight_nz[gi]    = |weight_field[gi];
            assign credit_nz[gi]    = |credit_reg[gi];
            // Weight is checked live so that writing 0 disables a port at once,
            // even while it still holds credit from the current round.
            assign live_req[gi]     = bus.request[gi] & weight_nz[gi];
            assign eligible[gi]     = live_req[gi] & credit_nz[gi];

            always_comb begin
                credit_next[gi] = credit_reg[gi];
                if (reload) begin
                    credit_next[gi] = weight_field[gi];
                end else if (consume && (grant_enc_reg == CL_PORTS'(gi)) && credit_nz[gi]) begin
                    credit_next[gi] = credit_reg[gi] - 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    credit_reg[gi] <= '0;
                end else begin
                    credit_reg[gi] <= credit_next[gi];
                end
            end
        end
    endgenerate

    // When the round is exhausted, the reloaded credits equal the weights, so
    // every live request is eligible again; arbitrate on that directly instead
    // of waiting a cycle for the reload to land.
    assign need_reload = (|live_req) & ~(|eligible);
    assign pick_elig   = need_reload ? live_req : eligible;

    axis_rr_pick #(
        .PORTS    (PORTS),
        .CL_PORTS (CL_PORTS)
    ) u_pick (
        .eligible    (pick_elig),
        .ptr         (ptr_reg),
        .pick_onehot (pick_onehot),
        .pick_index  (pick_index),
        .found       (pick_found)
    );

    // Only the granted port's acknowledge bit matters.
    assign ack_granted = bus.acknowledge[grant_enc_reg];
    assign last_credit = (credit_reg[grant_enc_reg] == WEIGHT_WIDTH'(1));

    // ------------------------------------------------------------------
    // FSM: next state and registered outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_next       = state_reg;
        grant_next       = grant_reg;
        grant_valid_next = grant_valid_reg;
        grant_enc_next   = grant_enc_reg;
        round_start_next = 1'b0;
        ptr_next         = ptr_reg;
        reload           = 1'b0;
        consume          = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (|live_req) begin
                    reload = need_reload;
                    if (pick_found) begin
                        grant_next       = pick_onehot;
                        grant_enc_next   = pick_index;
                        grant_valid_next = 1'b1;
                        round_start_next = need_reload;
                        state_next       = ST_GRANT;
                    end
                end
            end

            ST_GRANT: begin
                if (ack_granted) begin
                    consume = 1'b1;
                    // A port keeps priority while it still has quota; once it
                    // spends its last credit the pointer moves past it.
                    if (last_credit) begin
                        if (grant_enc_reg == CL_PORTS'(PORTS - 1)) begin
                            ptr_next = '0;
                        end else begin
                            ptr_next = grant_enc_reg + 1'b1;
                        end
                    end else begin
                        ptr_next = grant_enc_reg;
                    end
                    grant_next       = '0;
                    grant_enc_next   = '0;
                    grant_valid_next = 1'b0;
                    state_next       = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            grant_reg       <= '0;
            grant_valid_reg <= 1'b0;
            grant_enc_reg   <= '0;
            round_start_reg <= 1'b0;
            ptr_reg         <= '0;
        end else begin
            state_reg       <= state_next;
            grant_reg       <= grant_next;
            grant_valid_reg <= grant_valid_next;
            grant_enc_reg   <= grant_enc_next;
            round_start_reg <= round_start_next;
            ptr_reg         <= ptr_next;
        end
    end

    assign bus.grant         = grant_reg;
    assign bus.grant_valid   = grant_valid_reg;
    assign bus.grant_encoded = grant_enc_reg;
    assign bus.round_start   = round_start_reg;

endmodule

// File: tb/tb_axis_wrr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axis_wrr_arbiter
//   Directed test of the weighted round-robin arbiter: reset behaviour,
//   weighted sharing, grant hold, stray acknowledge, reconfiguration and
//   pointer wrap. Expected grant sequences are written out by hand.
// ---------------------------------------------------------------------------
module tb_axis_wrr_arbiter;

    localparam int PORTS = 4;
    localparam int WW    = 4;
    localparam int CLP   = 2;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    axis_wrr_arbiter_if #(.PORTS(PORTS), .WEIGHT_WIDTH(WW), .CL_PORTS(CLP)) bus ();

    axis_wrr_arbiter #(
        .PORTS        (PORTS),
        .WEIGHT_WIDTH (WW),
        .CL_PORTS     (CLP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total_cnt = 0;
    int bad_cnt   = 0;

    int seq_port [16];
    bit seq_rs   [16];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_weights(input int w0, input int w1, input int w2, input int w3);
        bus.cfg_weight = {WW'(w3), WW'(w2), WW'(w1), WW'(w0)};
    endtask

    task automatic do_reset();
        rst_n           = 1'b0;
        bus.request     = '0;
        bus.acknowledge = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Wait for the next grant, check it, acknowledge it for one cycle and
    // check that the grant drops. Under continuous load the grant arrives
    // exactly one cycle after the previous one dropped.
    task automatic expect_grant(input string tag, input int port, input bit rs);
        int waits;
        logic [PORTS-1:0] one_hot;
        waits   = 0;
        one_hot = PORTS'(1) << port;
        while (bus.grant_valid !== 1'b1 && waits < 20) begin
            tick();
            waits++;
        end
        check_eq({tag, ".valid"}, 32'(bus.grant_valid), 32'd1);
        check_eq({tag, ".wait"}, 32'(waits), 32'd1);
        check_eq({tag, ".enc"}, 32'(bus.grant_encoded), 32'(port));
        check_eq({tag, ".onehot"}, 32'(bus.grant), 32'(one_hot));
        check_eq({tag, ".round"}, 32'(bus.round_start), 32'(rs));
        $display("pkt %s: port=%0d round_start=%0b", tag, bus.grant_encoded, bus.round_start);
        bus.acknowledge = one_hot;
        tick();
        bus.acknowledge = '0;
        check_eq({tag, ".drop"}, 32'(bus.grant_valid), 32'd0);
    endtask

    task automatic run_seq(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            expect_grant($sformatf("%s[%0d]", tag, k), seq_port[k], seq_rs[k]);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n           = 1'b0;
        bus.request     = '0;
        bus.acknowledge = '0;
        bus.cfg_weight  = '0;
        tick();
        tick();

        // ---------------- reset state ----------------
        check_eq("rst.grant", 32'(bus.grant), 32'd0);
        check_eq("rst.valid", 32'(bus.grant_valid), 32'd0);
        check_eq("rst.enc", 32'(bus.grant_encoded), 32'd0);
        check_eq("rst.round", 32'(bus.round_start), 32'd0);

        // ---------------- async reset mid-grant ----------------
        rst_n = 1'b1;
        set_weights(1, 1, 1, 1);
        tick();
        bus.request = 4'b0100;
        tick();
        check_eq("pre.grant", 32'(bus.grant), 32'h4);
        check_eq("pre.enc", 32'(bus.grant_encoded), 32'd2);
        check_eq("pre.round", 32'(bus.round_start), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async.grant", 32'(bus.grant), 32'd0);
        check_eq("async.valid", 32'(bus.grant_valid), 32'd0);
        check_eq("async.enc", 32'(bus.grant_encoded), 32'd0);
        check_eq("async.round", 32'(bus.round_start), 32'd0);
        $display("async reset mid-grant: grant=%b valid=%0b", bus.grant, bus.grant_valid);
        tick();
        rst_n       = 1'b1;
        bus.request = 4'b0001;
        tick();
        check_eq("post.grant", 32'(bus.grant), 32'h1);
        check_eq("post.valid", 32'(bus.grant_valid), 32'd1);
        check_eq("post.round", 32'(bus.round_start), 32'd1);
        tick();
        check_eq("post.round_pulse", 32'(bus.round_start), 32'd0);
        bus.acknowledge = 4'b0001;
        tick();
        bus.acknowledge = '0;
        bus.request     = '0;
        check_eq("post.drop", 32'(bus.grant_valid), 32'd0);

        // ---------------- weighted sharing ----------------
        do_reset();
        set_weights(3, 0, 2, 1);
        bus.request = 4'b1111;
        seq_port = '{0, 0, 0, 2, 2, 3, 0, 0, 0, 2, 2, 3, 0, 0, 0, 0};
        seq_rs   = '{1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        run_seq("wrr", 12);

        // ---------------- grant hold ----------------
        do_reset();
        set_weights(1, 1, 1, 1);
        bus.request = 4'b0100;
        tick();
        check_eq("hold.start", 32'(bus.grant), 32'h4);
        bus.request = '0;
        for (int k = 0; k < 10; k++) begin
            tick();
            check_eq($sformatf("hold.c%0d", k), 32'(bus.grant), 32'h4);
        end
        check_eq("hold.round", 32'(bus.round_start), 32'd0);
        $display("hold: grant=%b held 10 cycles", bus.grant);
        bus.acknowledge = 4'b0100;
        tick();
        bus.acknowledge = '0;
        check_eq("hold.drop", 32'(bus.grant_valid), 32'd0);
        check_eq("hold.clear", 32'(bus.grant), 32'd0);

        // ---------------- stray acknowledge ----------------
        do_reset();
        set_weights(2, 1, 0, 0);
        bus.request = 4'b0011;
        tick();
        check_eq("stray.grant", 32'(bus.grant), 32'h1);
        check_eq("stray.round", 32'(bus.round_start), 32'd1);
        bus.acknowledge = 4'b0010;
        tick();
        bus.acknowledge = '0;
        check_eq("stray.hold", 32'(bus.grant), 32'h1);
        check_eq("stray.valid", 32'(bus.grant_valid), 32'd1);
        $display("stray ack: grant=%b valid=%0b", bus.grant, bus.grant_valid);
        bus.acknowledge = 4'b0001;
        tick();
        bus.acknowledge = '0;
        check_eq("stray.drop", 32'(bus.grant_valid), 32'd0);
        // p0 has one credit left, p1 still has its full single credit.
        seq_port = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        seq_rs   = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        run_seq("stray", 2);

        // ---------------- weight written to 0 mid-round ----------------
        do_reset();
        set_weights(3, 0, 2, 1);
        bus.request = 4'b1111;
        expect_grant("w0off.first", 0, 1'b1);
        set_weights(0, 0, 2, 1);
        seq_port = '{2, 2, 3, 2, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        seq_rs   = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        run_seq("w0off", 6);

        // ---------------- weight raised mid-round ----------------
        do_reset();
        set_weights(3, 0, 2, 1);
        bus.request = 4'b1111;
        seq_port = '{0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        seq_rs   = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        run_seq("w2up.a", 4);
        set_weights(3, 0, 5, 1);
        seq_port = '{2, 3, 0, 0, 0, 2, 2, 2, 2, 2, 3, 0, 0, 0, 0, 0};
        seq_rs   = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        run_seq("w2up.b", 11);

        // ---------------- pointer wrap ----------------
        do_reset();
        set_weights(1, 1, 1, 1);
        bus.request = 4'b1001;
        seq_port = '{0, 3, 0, 3, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        seq_rs   = '{1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        run_seq("wrap", 6);

        bus.request = '0;
        tick();
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/axis_wrr_arbiter.md
# axis_wrr_arbiter

Packet-granular weighted round-robin arbiter that shares one AXI-Stream output among PORTS requesters. It sits in place of the plain round-robin arbiter in front of an output mux of the stream switch. Each input gets a runtime-programmable packet quota per round. A grant is held from selection until the granted port acknowledges its tlast beat.

## Interface
- PORTS, default 4: number of requesters, minimum 2.
- WEIGHT_WIDTH, default 4: width of each per-port weight and credit counter.
- CL_PORTS, default $clog2(PORTS): width of the encoded grant.
- clk  input  1: single clock; all logic on the rising edge.
- rst_n  input  1: reset, asynchronous assert, active-low.
- request  input  PORTS: a port has a packet pending.
- acknowledge  input  PORTS: the granted port's tlast beat handshakes this cycle.
- cfg_weight  input  PORTS*WEIGHT_WIDTH: packets per round for each port; 0 disables the port.
- grant  output  PORTS: one-hot grant, registered.
- grant_valid  output  1: a grant is active, registered.
- grant_encoded  output  CL_PORTS: index of the granted port, registered.
- round_start  output  1: one-cycle pulse when all credits are reloaded.

## Operation
- State per port:
  - credit[i] (WEIGHT_WIDTH bits).
  - rotation pointer ptr (CL_PORTS bits).
  - FSM with states IDLE and GRANT.
- Eligibility: eligible[i] = request[i] && cfg_weight[i] != 0 && credit[i] != 0.
- IDLE:
  - If there is no request with nonzero weight, stay in IDLE.
  - If requests exist but no port is eligible, reload credit[i] = cfg_weight[i] for all i and assert round_start. In the same cycle, arbitrate using the reloaded values.
  - Selection picks the first eligible port scanning ptr, ptr+1, … modulo PORTS. The grant is registered and FSM moves to GRANT.
- GRANT:
  - Grant outputs hold, regardless of request, until acknowledge[grant_encoded]=1.
  - On that acknowledge, decrement credit[grant_encoded] by 1.
  - If the decremented credit is 0, ptr = grant_encoded+1 modulo PORTS. Otherwise ptr = grant_encoded, so the port keeps priority while it has quota.
  - Clear the grant outputs and return to IDLE.
- acknowledge bits of non-granted ports, and any acknowledge in IDLE, are ignored.
- A cfg_weight change does not touch stored credits; it takes effect at the next reload. Exception: a weight written to 0 makes that port ineligible immediately, including mid-round.
- Credits never underflow, because decrement only happens on a granted port, which has nonzero credit.

## Timing
- Reset values: grant=0, grant_valid=0, grant_encoded=0, round_start=0, all credits=0, ptr=0, FSM=IDLE. Because credits are 0, the first arbitration after reset always reloads and pulses round_start.
- Latency:
  - request rising in cycle t produces grant_valid=1 in cycle t+1.
  - An acknowledge in cycle t drops grant_valid in cycle t+1.
  - The next grant appears no earlier than t+2, so there is exactly one idle cycle between packets under continuous load.
- round_start is registered and coincides with the first grant of the new round.
- Simultaneous acknowledge and new requests: the acknowledge is processed first; new requests are considered in the following IDLE cycle.
- When rst_n is asserted mid-packet, all outputs clear asynchronously, with no acknowledge required.

## Structure
- Shared package axis_sched_pkg holds the FSM state encodings (IDLE=0, GRANT=1) and the weight-field slicing helper.
- One sub-module, axis_rr_pick, is a combinational rotating-priority picker: inputs are the eligible vector and ptr, outputs are a one-hot vector, the encoded index and a found flag.
- Top level contains the FSM, credit counters, pointer and output registers.

## Test plan
- **Reset:** rst_n low mid-grant → all outputs 0 immediately. After release, request=0001 → grant=0001 one cycle later, with round_start=1 in that same cycle.
- **Weighted sharing:**
  - Setup: weights p0=3, p1=0, p2=2, p3=1; request=1111 constant; acknowledge pulsed one cycle after each grant.
  - Required: grant_encoded sequence 0,0,0,2,2,3, then repeating. round_start accompanies each first p0 grant. p1 is never granted.
- **Grant hold:**
  - Setup: port 2 granted, request[2] dropped, acknowledge withheld for 10 cycles.
  - Required: grant stays 0100 for all 10 cycles. On acknowledge[2], grant_valid=0 the next cycle.
- **Stray acknowledge:** acknowledge=0010 while port 0 is granted → no change to grant or credits.
- **Mid-round reconfiguration:**
  - Weight of p0 written from 3 to 0 after its first packet → p0 is never granted again.
  - Weight of p2 written from 2 to 5 mid-round → p2 gets 2 packets this round and 5 after the reload.
- **Pointer wrap:** weights all 1, only p3 and p0 requesting → grants alternate 3,0,3,0 with ptr wrapping from 3 to 0.
